// File: rtl/mem_access_unit_pkg.sv
// Shared op-codes, FSM states and small helpers for the data-memory access unit.
// Optional statistics counters are enabled in the top by defining MAU_STATS_EN.
`default_nettype none

package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MAU_OP_LB  = 3'd0,
    MAU_OP_LH  = 3'd1,
    MAU_OP_LW  = 3'd2,
    MAU_OP_LBU = 3'd3,
    MAU_OP_LHU = 3'd4,
    MAU_OP_SB  = 3'd5,
    MAU_OP_SH  = 3'd6,
    MAU_OP_SW  = 3'd7
  } mau_op_e;

  typedef enum logic [1:0] {
    MAU_ST_IDLE  = 2'd0,
    MAU_ST_READ  = 2'd1,
    MAU_ST_WRITE = 2'd2,
    MAU_ST_RESP  = 2'd3
  } mau_state_e;

  function automatic logic is_store(mau_op_e op);
    return op inside {MAU_OP_SB, MAU_OP_SH, MAU_OP_SW};
  endfunction

  function automatic logic is_half(mau_op_e op);
    return op inside {MAU_OP_LH, MAU_OP_LHU, MAU_OP_SH};
  endfunction

  function automatic logic is_word(mau_op_e op);
    return op inside {MAU_OP_LW, MAU_OP_SW};
  endfunction

  function automatic logic [15:0] sat_inc(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory bus of the access unit.
// The unit uses the slave modport; execute stage and memory use master.
`default_nettype none

interface mem_access_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              Req_valid;
  logic              Req_ready;
  logic [2:0]        Req_op;
  logic [ADDR_W-1:0] Req_addr;
  logic [31:0]       Req_wdata;
  logic              Resp_valid;
  logic              Resp_ready;
  logic [31:0]       Resp_rdata;
  logic              Resp_err;
  logic [ADDR_W-1:0] DataAddress;
  logic [31:0]       Mem_wdata;
  logic              MemRead_en;
  logic              MemWrite_en;
  logic [31:0]       Mem_rdata;

  modport master (
    output Req_valid, Req_op, Req_addr, Req_wdata, Resp_ready, Mem_rdata,
    input  Req_ready, Resp_valid, Resp_rdata, Resp_err,
    input  DataAddress, Mem_wdata, MemRead_en, MemWrite_en
  );

  modport slave (
    input  Req_valid, Req_op, Req_addr, Req_wdata, Resp_ready, Mem_rdata,
    output Req_ready, Resp_valid, Resp_rdata, Resp_err,
    output DataAddress, Mem_wdata, MemRead_en, MemWrite_en
  );
endinterface

`default_nettype wire

// File: rtl/mau_lane_align.sv
// Big-endian lane extraction with sign/zero extension for loads, and lane
// merge of store data into a read word for sub-word read-modify-write.
`default_nettype none

module mau_lane_align
  import mem_access_unit_pkg::*;
(
  input  mau_op_e     op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  byte_shift;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] byte_mask;

  always_comb begin
    // Offset 0 is the most significant byte, so the shift is (3-b)*8.
    byte_shift = {~offset_i, 3'b000};
    byte_v     = word_i[byte_shift +: 8];
    half_v     = offset_i[1] ? word_i[15:0] : word_i[31:16];
    byte_mask  = 32'h0000_00FF << byte_shift;
    load_o     = word_i;
    merge_o    = word_i;
    case (op_i)
      MAU_OP_LB:  load_o  = {{24{byte_v[7]}}, byte_v};
      MAU_OP_LBU: load_o  = {24'h0, byte_v};
      MAU_OP_LH:  load_o  = {{16{half_v[15]}}, half_v};
      MAU_OP_LHU: load_o  = {16'h0, half_v};
      MAU_OP_SB:  merge_o = (word_i & ~byte_mask) | ({24'h0, wdata_i[7:0]} << byte_shift);
      MAU_OP_SH:  merge_o = offset_i[1] ? {word_i[31:16], wdata_i} : {wdata_i, word_i[15:0]};
      default:    ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// Load/store initiator for the multicycle CPU data memory: IDLE/READ/WRITE/RESP
// FSM with sub-word RMW stores. Define MAU_STATS_EN for Stat_* counters.
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic               CLK_in,
  input  logic               RST_n,
  mem_access_unit_if.slave   bus,
  output logic [15:0]        Stat_loads,
  output logic [15:0]        Stat_stores,
  output logic [15:0]        Stat_errs
);

  mau_state_e        state_q;
  mau_op_e           op_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic [ADDR_W-1:0] daddr_q;
  logic [31:0]       mwdata_q;
  logic              re_q;
  logic              we_q;

  mau_op_e           req_op;
  logic [ADDR_W-1:0] req_aligned;
  logic              req_err;
  logic [31:0]       load_d;
  logic [31:0]       merge_d;

  assign req_op      = mau_op_e'(bus.Req_op);
  assign req_aligned = bus.Req_addr & ~ADDR_W'(3);
  assign req_err     = (is_half(req_op) && bus.Req_addr[0])
                    || (is_word(req_op) && (bus.Req_addr[1:0] != 2'b00))
                    || (req_aligned > ADDR_W'(MEM_BYTES - 4));

  mau_lane_align u_lane_align (
    .op_i     (op_q),
    .offset_i (off_q),
    .word_i   (bus.Mem_rdata),
    .wdata_i  (wdata_q),
    .load_o   (load_d),
    .merge_o  (merge_d)
  );

  // Enables are registered so an asynchronous reset removes them at once.
  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= MAU_ST_IDLE;
      op_q         <= MAU_OP_LB;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      daddr_q      <= '0;
      mwdata_q     <= 32'h0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      case (state_q)
        MAU_ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_ready_q && bus.Req_valid) begin
            req_ready_q  <= 1'b0;
            op_q         <= req_op;
            off_q        <= bus.Req_addr[1:0];
            wdata_q      <= bus.Req_wdata[15:0];
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            if (req_err) begin
              resp_err_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= MAU_ST_RESP;
            end else begin
              daddr_q <= req_aligned;
              if (req_op == MAU_OP_SW) begin
                mwdata_q <= bus.Req_wdata;
                we_q     <= 1'b1;
                state_q  <= MAU_ST_WRITE;
              end else begin
                re_q    <= 1'b1;
                state_q <= MAU_ST_READ;
              end
            end
          end
        end
        MAU_ST_READ: begin
          re_q <= 1'b0;
          if (is_store(op_q)) begin
            mwdata_q <= merge_d;
            we_q     <= 1'b1;
            state_q  <= MAU_ST_WRITE;
          end else begin
            resp_rdata_q <= load_d;
            resp_valid_q <= 1'b1;
            state_q      <= MAU_ST_RESP;
          end
        end
        MAU_ST_WRITE: begin
          we_q         <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= MAU_ST_RESP;
        end
        MAU_ST_RESP: begin
          if (bus.Resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= MAU_ST_IDLE;
          end
        end
        default: state_q <= MAU_ST_IDLE;
      endcase
    end
  end

  assign bus.Req_ready   = req_ready_q;
  assign bus.Resp_valid  = resp_valid_q;
  assign bus.Resp_rdata  = resp_rdata_q;
  assign bus.Resp_err    = resp_err_q;
  assign bus.DataAddress = daddr_q;
  assign bus.Mem_wdata   = mwdata_q;
  assign bus.MemRead_en  = re_q;
  assign bus.MemWrite_en = we_q;

`ifdef MAU_STATS_EN
  logic        resp_hs;
  logic [15:0] loads_q;
  logic [15:0] stores_q;
  logic [15:0] errs_q;

  assign resp_hs = (state_q == MAU_ST_RESP) && bus.Resp_ready;

  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      loads_q  <= 16'h0;
      stores_q <= 16'h0;
      errs_q   <= 16'h0;
    end else if (resp_hs) begin
      if (resp_err_q)          errs_q   <= sat_inc(errs_q);
      else if (is_store(op_q)) stores_q <= sat_inc(stores_q);
      else                     loads_q  <= sat_inc(loads_q);
    end
  end

  assign Stat_loads  = loads_q;
  assign Stat_stores = stores_q;
  assign Stat_errs   = errs_q;
`else
  assign Stat_loads  = 16'h0;
  assign Stat_stores = 16'h0;
  assign Stat_errs   = 16'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference model, random and
// directed requests, back-pressure, reset-during-write and statistics checks.
`default_nettype none

module tb_mem_access_unit;

  localparam int MEM_BYTES = 64;
  localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LBU = 3'd3,
                         OP_LHU = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          re_n;
    int          we_n;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    int          cls;
  } exp_t;

  logic        CLK_in = 1'b0;
  logic        RST_n  = 1'b0;
  logic [15:0] Stat_loads, Stat_stores, Stat_errs;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
    .CLK_in      (CLK_in),
    .RST_n       (RST_n),
    .bus         (bus),
    .Stat_loads  (Stat_loads),
    .Stat_stores (Stat_stores),
    .Stat_errs   (Stat_errs)
  );

  always #5 CLK_in = ~CLK_in;

  logic [7:0] mem  [0:MEM_BYTES-1];
  logic [7:0] refm [0:MEM_BYTES-1];
  logic       preload = 1'b0;
  exp_t       exp_q[$];
  int         errs = 0, chks = 0;
  int         cyc = 0, accept_cyc = 0;
  int         re_cnt = 0, we_cnt = 0;
  int         n_loads = 0, n_stores = 0, n_errs = 0;
  bit         bp = 1'b0;

  always @(posedge CLK_in) cyc <= cyc + 1;

  // Memory: combinational big-endian read, commit on the mid-cycle negedge.
  logic [5:0] rd_a;
  assign rd_a = {bus.DataAddress[5:2], 2'b00};
  assign bus.Mem_rdata = (bus.DataAddress < MEM_BYTES) ?
      {mem[rd_a], mem[rd_a + 6'd1], mem[rd_a + 6'd2], mem[rd_a + 6'd3]} : 32'h0;

  always @(negedge CLK_in) begin
    if (preload) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= refm[i];
    end else if (bus.MemWrite_en && bus.DataAddress < MEM_BYTES) begin
      mem[rd_a]        <= bus.Mem_wdata[31:24];
      mem[rd_a + 6'd1] <= bus.Mem_wdata[23:16];
      mem[rd_a + 6'd2] <= bus.Mem_wdata[15:8];
      mem[rd_a + 6'd3] <= bus.Mem_wdata[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    chks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: operates on a plain byte array, one request at a time.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input bit apply);
    exp_t       e;
    logic [7:0] w [4];
    int         al, b, n;
    bit         mis, oor;
    al  = int'(addr & ~32'd3);
    b   = int'(addr[1:0]);
    mis = ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0])
       || ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00);
    oor = (addr & ~32'd3) > 32'(MEM_BYTES - 4);
    e = '{rdata: 32'h0, err: 1'b0, lat: 2, re_n: 1, we_n: 0,
          maddr: addr & ~32'd3, mwdata: 32'h0, cls: 0};
    if (mis || oor) begin
      e.err = 1'b1; e.lat = 1; e.re_n = 0; e.cls = 2;
    end else begin
      for (int j = 0; j < 4; j++) w[j] = refm[al + j];
      case (op)
        OP_LB:  e.rdata = {{24{w[b][7]}}, w[b]};
        OP_LBU: e.rdata = {24'h0, w[b]};
        OP_LH:  e.rdata = {{16{w[b][7]}}, w[b], w[b+1]};
        OP_LHU: e.rdata = {16'h0, w[b], w[b+1]};
        OP_LW:  e.rdata = {w[0], w[1], w[2], w[3]};
        OP_SB:  begin w[b] = wd[7:0]; e.lat = 3; e.we_n = 1; e.cls = 1; end
        OP_SH:  begin w[b] = wd[15:8]; w[b+1] = wd[7:0]; e.lat = 3; e.we_n = 1; e.cls = 1; end
        default: begin
          w[0] = wd[31:24]; w[1] = wd[23:16]; w[2] = wd[15:8]; w[3] = wd[7:0];
          e.lat = 2; e.re_n = 0; e.we_n = 1; e.cls = 1;
        end
      endcase
      e.mwdata = {w[0], w[1], w[2], w[3]};
      if (apply && e.cls == 1)
        for (int j = 0; j < 4; j++) refm[al + j] = w[j];
    end
    n = 0;
    @(negedge CLK_in);
    while (!bus.Req_ready && n < 100) begin @(negedge CLK_in); n++; end
    if (!bus.Req_ready) begin
      chk("req_ready_timeout", 32'(bus.Req_ready), 32'h1);
    end else begin
      bus.Req_valid = 1'b1; bus.Req_op = op; bus.Req_addr = addr; bus.Req_wdata = wd;
      exp_q.push_back(e);
      @(posedge CLK_in); #1;
      accept_cyc = cyc; re_cnt = 0; we_cnt = 0;
      bus.Req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge CLK_in); n++; end
    chk("drain_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"},  32'(bus.Req_ready),  32'h0);
    chk({tag, "_resp_valid"}, 32'(bus.Resp_valid), 32'h0);
    chk({tag, "_resp_rdata"}, bus.Resp_rdata,      32'h0);
    chk({tag, "_resp_err"},   32'(bus.Resp_err),   32'h0);
    chk({tag, "_daddr"},      bus.DataAddress,     32'h0);
    chk({tag, "_mwdata"},     bus.Mem_wdata,       32'h0);
    chk({tag, "_mre"},        32'(bus.MemRead_en), 32'h0);
    chk({tag, "_mwe"},        32'(bus.MemWrite_en),32'h0);
    chk({tag, "_stat_loads"}, 32'(Stat_loads),     32'h0);
    chk({tag, "_stat_stores"},32'(Stat_stores),    32'h0);
    chk({tag, "_stat_errs"},  32'(Stat_errs),      32'h0);
  endtask

  // Response-side back-pressure, updated just after each active edge.
  initial begin
    bus.Resp_ready = 1'b0;
    forever begin
      @(posedge CLK_in); #1;
      bus.Resp_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: samples on the negedge and scores each response handshake.
  initial begin
    bit          seen = 1'b0;
    logic [31:0] h_rdata;
    logic        h_err;
    exp_t        e;
    forever begin
      @(negedge CLK_in);
      if (!RST_n) begin
        seen = 1'b0;
      end else begin
        if (bus.MemRead_en && bus.MemWrite_en) chk("both_enables", 32'h1, 32'h0);
        if (bus.MemRead_en) begin
          re_cnt++;
          if (exp_q.size() != 0) chk("read_addr", bus.DataAddress, exp_q[0].maddr);
        end
        if (bus.MemWrite_en) begin
          we_cnt++;
          if (exp_q.size() != 0) begin
            chk("write_addr",  bus.DataAddress, exp_q[0].maddr);
            chk("write_wdata", bus.Mem_wdata,   exp_q[0].mwdata);
          end
        end
        if (bus.Resp_valid) begin
          chk("req_ready_busy", 32'(bus.Req_ready), 32'h0);
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'h1, 32'h0);
          end else begin
            if (!seen) begin
              seen = 1'b1; h_rdata = bus.Resp_rdata; h_err = bus.Resp_err;
              chk("latency", 32'(cyc - accept_cyc + 1), 32'(exp_q[0].lat));
            end else begin
              chk("hold_rdata", bus.Resp_rdata, h_rdata);
              chk("hold_err",   32'(bus.Resp_err), 32'(h_err));
            end
            if (bus.Resp_ready) begin
              e = exp_q.pop_front();
              chk("rdata",     bus.Resp_rdata,     e.rdata);
              chk("err",       32'(bus.Resp_err),  32'(e.err));
              chk("read_cyc",  32'(re_cnt),        32'(e.re_n));
              chk("write_cyc", 32'(we_cnt),        32'(e.we_n));
              if (e.cls == 0) n_loads++; else if (e.cls == 1) n_stores++; else n_errs++;
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    bus.Req_valid = 1'b0; bus.Req_op = 3'd0; bus.Req_addr = 32'h0; bus.Req_wdata = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) refm[i] = 8'($urandom);
    refm[16] = 8'h80; refm[17] = 8'h12; refm[18] = 8'h34; refm[19] = 8'hFE;
    refm[32] = 8'h11; refm[33] = 8'h22; refm[34] = 8'h33; refm[35] = 8'h44;
    preload = 1'b1;
    repeat (2) @(negedge CLK_in);
    preload = 1'b0;
    #1 chk_outputs_zero("reset");
    @(negedge CLK_in); RST_n = 1'b1;

    issue(OP_LB,  32'h10, 32'h0, 1'b1);
    issue(OP_LBU, 32'h10, 32'h0, 1'b1);
    issue(OP_LH,  32'h12, 32'h0, 1'b1);
    issue(OP_LW,  32'h10, 32'h0, 1'b1);
    issue(OP_SB,  32'h21, 32'hAB, 1'b1);
    issue(OP_LW,  32'h20, 32'h0, 1'b1);
    issue(OP_LH,  32'h03, 32'h0, 1'b1);
    issue(OP_SW,  32'h06, 32'h0, 1'b1);
    issue(OP_LW,  32'h3D, 32'h0, 1'b1);
    drain();

    // Back-pressure with an ignored request pulse inside the window.
    bp = 1'b1;
    @(posedge CLK_in); #2;
    issue(OP_LW, 32'h10, 32'h0, 1'b1);
    n = 0;
    while (!bus.Resp_valid && n < 20) begin @(negedge CLK_in); n++; end
    chk("bp_resp_valid", 32'(bus.Resp_valid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK_in); #1;
      chk("bp_hold_valid", 32'(bus.Resp_valid), 32'h1);
      if (k == 1) begin
        bus.Req_valid = 1'b1; bus.Req_op = OP_SW; bus.Req_addr = 32'h10; bus.Req_wdata = 32'h0;
        @(posedge CLK_in); #1 bus.Req_valid = 1'b0;
      end
    end
    bp = 1'b0;
    drain();

    // Reset while the write enable is up, ahead of the commit negedge.
    issue(OP_SW, 32'h30, 32'hDEADBEEF, 1'b0);
    #1 chk("we_before_rst", 32'(bus.MemWrite_en), 32'h1);
    RST_n = 1'b0;
    #1 chk_outputs_zero("async_rst");
    exp_q.delete();
    n_loads = 0; n_stores = 0; n_errs = 0;
    repeat (2) @(negedge CLK_in);
    #1 RST_n = 1'b1;
    chk("rst_word_kept", {mem[48], mem[49], mem[50], mem[51]},
                         {refm[48], refm[49], refm[50], refm[51]});

    for (int t = 0; t < 150; t++)
      issue(3'($urandom_range(0, 7)), 32'($urandom_range(0, 67)), $urandom, 1'b1);
    drain();
    repeat (3) @(negedge CLK_in);

`ifdef MAU_STATS_EN
    chk("stat_loads",  32'(Stat_loads),  32'(n_loads));
    chk("stat_stores", 32'(Stat_stores), 32'(n_stores));
    chk("stat_errs",   32'(Stat_errs),   32'(n_errs));
`else
    chk("stat_loads",  32'(Stat_loads),  32'h0);
    chk("stat_stores", 32'(Stat_stores), 32'h0);
    chk("stat_errs",   32'(Stat_errs),   32'h0);
`endif
    for (int wi = 0; wi < MEM_BYTES; wi += 4)
      chk("mem_word", {mem[wi], mem[wi+1], mem[wi+2], mem[wi+3]},
                      {refm[wi], refm[wi+1], refm[wi+2], refm[wi+3]});

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

`default_nettype wire
